// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Combinational only: no latency and no backpressure.
package regfile_pkg;
   localparam int REG_ADDR_W     = 5;
   localparam int REG_COUNT      = 32;
   localparam int DATA_W_DEFAULT = 32;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   function automatic logic [REG_COUNT-1:0] idx_onehot(input reg_idx_t idx);
      logic [REG_COUNT-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction
endpackage

// File: rtl/Decoder5to32.sv
// 5-to-32 one-hot decoder with enable, all outputs low when En is low.
// Combinational: zero latency, no backpressure.
module Decoder5to32 (
   input  logic [4:0]  in,
   input  logic        En,
   output logic [31:0] out
);
   always_comb begin
      out = '0;
      if (En) out[in] = 1'b1;
   end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits; reads, pending flags and busy_any are registered (1 cycle).
// Always accepts writes, reserves and reads; no backpressure. Optional same-cycle write bypass: define REGFILE_BYPASS_EN.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int NREG   = REG_COUNT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [4:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rsv_en,
   input  logic [4:0]        rsv_addr,
   input  logic [4:0]        raddr_a,
   input  logic [4:0]        raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              pend_a,
   output logic              pend_b,
   output logic              busy_any
);
   logic [31:0]       dec_oh;
   logic [NREG-1:0]   wen_oh;
   logic [NREG-1:0]   rsv_oh;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   pend_q, pend_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic              busy_q, busy_d;

   Decoder5to32 u_wdec (
      .in  (waddr),
      .En  (we),
      .out (dec_oh)
   );

   // Register 0 is hardwired: never written, never reserved.
   assign wen_oh = dec_oh & {{(NREG-1){1'b1}}, 1'b0};
   assign rsv_oh = rsv_en ? (idx_onehot(reg_idx_t'(rsv_addr)) & {{(NREG-1){1'b1}}, 1'b0}) : '0;

   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < NREG; i++) begin
         if (wen_oh[i]) regs_d[i] = wdata;
      end
      regs_d[0] = '0;
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_d[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   // Reserve is applied after the write-back clear so a new producer wins.
   always_comb begin
      pend_d = (pend_q & ~wen_oh) | rsv_oh;
      if (rst) pend_d = '0;
   end

   always_ff @(posedge clk) begin
      pend_q <= pend_d;
   end

   always_comb begin
`ifdef REGFILE_BYPASS_EN
      rdata_a_d = (we && (waddr == raddr_a) && (waddr != '0)) ? wdata : regs_q[raddr_a];
      rdata_b_d = (we && (waddr == raddr_b) && (waddr != '0)) ? wdata : regs_q[raddr_b];
      pend_a_d  = pend_d[raddr_a];
      pend_b_d  = pend_d[raddr_b];
`else
      rdata_a_d = regs_q[raddr_a];
      rdata_b_d = regs_q[raddr_b];
      pend_a_d  = pend_q[raddr_a];
      pend_b_d  = pend_q[raddr_b];
`endif
      busy_d = |pend_d;
      if (rst) begin
         rdata_a_d = '0;
         rdata_b_d = '0;
         pend_a_d  = 1'b0;
         pend_b_d  = 1'b0;
         busy_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      busy_q    <= busy_d;
   end

   assign rdata_a  = rdata_a_q;
   assign rdata_b  = rdata_b_q;
   assign pend_a   = pend_a_q;
   assign pend_b   = pend_b_q;
   assign busy_any = busy_q;
endmodule
